// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_pkg
//  Description : Shared binary16 constants, operand class type and the
//                operand classifier used by the fp16 multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_INF      = 16'h7C00;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp16_class_e;

    // Subnormals carry exponent 0 and are folded into ZERO (no subnormal support)
    function automatic fp16_class_e fp16_classify(input logic [15:0] x);
        fp16_class_e c;
        if (x[14:10] == 5'd0) begin
            c = ZERO;
        end else if (x[14:10] == 5'h1F) begin
            c = (x[9:0] != 10'd0) ? NAN : INF;
        end else begin
            c = NORMAL;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_dff.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_dff
//  Description : Plain register cell with synchronous active-high reset,
//                shared by the arithmetic blocks for pulse/flag staging.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp16_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Single register stage, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/fp16_mul_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_mul_round
//  Description : Combinational normalise / round / pack stage for the fp16
//                multiplier. Takes the 22-bit 1.10 x 1.10 mantissa product,
//                the unbiased-sum exponent, sign and combined operand class.
//                Build option FP16_MUL_RNE_EN selects round-to-nearest-even;
//                without it the fraction is truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp16_mul_round
    import fp16_pkg::*;
(
    input  logic [21:0] prod_i,
    input  logic [6:0]  exp_i,
    input  logic        sign_i,
    input  logic [1:0]  class_i,
    output logic [15:0] result_o
);

    logic signed [6:0] w_exp_s;
    logic signed [6:0] w_exp_n;
    logic signed [6:0] w_exp_r;
    logic [9:0]        w_frac_n;
    logic [9:0]        w_frac_r;

    assign w_exp_s = $signed(exp_i);

    // Product lies in [1,4): a set bit 21 means one extra right shift
    always_comb begin
        w_frac_n = prod_i[21] ? prod_i[20:11] : prod_i[19:10];
        w_exp_n  = prod_i[21] ? (w_exp_s + 7'sd1) : w_exp_s;
    end

`ifdef FP16_MUL_RNE_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [10:0] w_sum;

    // Round to nearest even; a carry out of the fraction bumps the exponent
    always_comb begin
        w_guard  = prod_i[21] ? prod_i[10] : prod_i[9];
        w_sticky = prod_i[21] ? (|prod_i[9:0]) : (|prod_i[8:0]);
        w_inc    = w_guard & (w_sticky | w_frac_n[0]);
        w_sum    = {1'b0, w_frac_n} + {10'd0, w_inc};
        if (w_sum[10]) begin
            w_frac_r = 10'd0;
            w_exp_r  = w_exp_n + 7'sd1;
        end else begin
            w_frac_r = w_sum[9:0];
            w_exp_r  = w_exp_n;
        end
    end
`else
    logic w_unused_lsbs;

    // Truncation: bits below the kept fraction are simply dropped
    always_comb begin
        w_frac_r = w_frac_n;
        w_exp_r  = w_exp_n;
    end

    assign w_unused_lsbs = ^prod_i[9:0];
`endif

    // Special-class override, then overflow to inf / flush to zero, then pack
    always_comb begin
        result_o = FP16_POS_ZERO;
        if (class_i == NAN) begin
            result_o = FP16_QNAN;
        end else if (class_i == INF) begin
            result_o = {sign_i, FP16_INF[14:0]};
        end else if (class_i == ZERO) begin
            result_o = {sign_i, 15'd0};
        end else if (w_exp_r >= 7'sd31) begin
            result_o = {sign_i, FP16_INF[14:0]};
        end else if (w_exp_r <= 7'sd0) begin
            result_o = {sign_i, 15'd0};
        end else begin
            result_o = {sign_i, w_exp_r[4:0], w_frac_r};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_multiplier
//  Description : Iterative binary16 multiplier. Shift-add mantissa datapath
//                consuming BITS_PER_CYCLE (1, 2 or 4) multiplier bits per
//                iteration, then one normalise/round/pack cycle. Start/clear/
//                valid pulse protocol, one operation in flight, fixed latency
//                of ITER+2 cycles from the accept edge to the valid pulse.
//                Build option FP16_MUL_RNE_EN: round-to-nearest-even
//                (truncation when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp16_multiplier
    import fp16_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] input_a,
    input  logic [15:0] input_b,
    input  logic        start_multiplier,
    input  logic        clear,
    output logic        busy,
    output logic        valid,
    output logic [15:0] result
);

    localparam int ITER  = (11 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int MPL_W = ITER * BITS_PER_CYCLE;
    localparam int ACC_W = 22;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2
    } state_e;

    state_e             state_q,  state_d;
    logic [3:0]         iter_q,   iter_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [ACC_W-1:0]   mcand_q,  mcand_d;
    logic [MPL_W-1:0]   mplier_q, mplier_d;
    logic               sign_q,   sign_d;
    logic [6:0]         exp_q,    exp_d;
    fp16_class_e        cls_q,    cls_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;
    logic [15:0]        result_q, result_d;

    logic               w_accept;
    logic               w_fire;
    fp16_class_e        w_cls_a;
    fp16_class_e        w_cls_b;
    fp16_class_e        w_cls;
    logic [10:0]        w_mant_a;
    logic [10:0]        w_mant_b;
    logic [BITS_PER_CYCLE-1:0] w_digit;
    logic [ACC_W-1:0]   w_pp;
    logic [15:0]        w_round;

    // A new op is taken only when fully idle, including the valid hand-off cycle
    assign w_accept = (state_q == S_IDLE) & ~busy_q & start_multiplier & ~clear;
    assign w_fire   = done_q & ~clear;

    // Operand decode: exponent 0 unpacks to a zero mantissa
    always_comb begin
        w_cls_a  = fp16_classify(input_a);
        w_cls_b  = fp16_classify(input_b);
        w_mant_a = (input_a[14:10] == 5'd0) ? 11'd0 : {1'b1, input_a[9:0]};
        w_mant_b = (input_b[14:10] == 5'd0) ? 11'd0 : {1'b1, input_b[9:0]};
        if (w_cls_a == NAN || w_cls_b == NAN ||
            (w_cls_a == INF && w_cls_b == ZERO) ||
            (w_cls_a == ZERO && w_cls_b == INF)) begin
            w_cls = NAN;
        end else if (w_cls_a == INF || w_cls_b == INF) begin
            w_cls = INF;
        end else if (w_cls_a == ZERO || w_cls_b == ZERO) begin
            w_cls = ZERO;
        end else begin
            w_cls = NORMAL;
        end
    end

    // Partial product of the shifted multiplicand and the current multiplier digit
    always_comb begin
        w_digit = mplier_q[BITS_PER_CYCLE-1:0];
        w_pp    = mcand_q * ACC_W'(w_digit);
    end

    // Next-state, datapath and output-register logic; clear overrides everything
    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        cls_d    = cls_q;
        done_d   = 1'b0;
        busy_d   = ~clear & (state_q != S_IDLE);
        result_d = w_fire ? w_round : result_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d  = S_MUL;
                    iter_d   = 4'd0;
                    acc_d    = '0;
                    mcand_d  = ACC_W'(w_mant_a);
                    mplier_d = MPL_W'(w_mant_b);
                    sign_d   = input_a[15] ^ input_b[15];
                    exp_d    = 7'(input_a[14:10]) + 7'(input_b[14:10]) - 7'(FP16_BIAS);
                    cls_d    = w_cls;
                end
            end
            S_MUL: begin
                acc_d    = acc_q + w_pp;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                iter_d   = iter_q + 4'd1;
                if (iter_q == 4'(ITER - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            iter_q   <= 4'd0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            exp_q    <= 7'd0;
            cls_q    <= ZERO;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= FP16_POS_ZERO;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            cls_q    <= cls_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            result_q <= result_d;
        end
    end

    fp16_mul_round u_round (
        .prod_i   (acc_q),
        .exp_i    (exp_q),
        .sign_i   (sign_q),
        .class_i  (cls_q),
        .result_o (w_round)
    );

    fp16_dff #(.WIDTH(1)) u_valid_dff (
        .clk   (clk),
        .reset (reset),
        .d_i   (w_fire),
        .q_o   (valid)
    );

    assign busy   = busy_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp16_multiplier
//  Description : Self-checking bench for fp16_multiplier. Three instances
//                (BITS_PER_CYCLE = 1, 2, 4) share the stimulus; results,
//                latency, busy window and control behaviour are checked
//                against constant vectors and a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        clear;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy_w   [3];
    logic        valid_w  [3];
    logic [15:0] result_w [3];

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] cur_ops;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fp16_multiplier #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .clk              (clk),
            .reset            (reset),
            .input_a          (a),
            .input_b          (b),
            .start_multiplier (start),
            .clear            (clear),
            .busy             (busy_w[g]),
            .valid            (valid_w[g]),
            .result           (result_w[g])
        );
    end

    function automatic int iters(input int i);
        return (i == 0) ? 11 : ((i == 1) ? 6 : 3);
    endfunction

    // Value-level binary16 product: exact integer product, then round by remainder
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int     ex, ey, k, sh, e;
        bit     s, xn, yn, xi, yi, xz, yz;
        longint p, q, rem, half;
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        s  = x[15] ^ y[15];
        xn = (ex == 31) && (x[9:0] != 10'd0);
        yn = (ey == 31) && (y[9:0] != 10'd0);
        xi = (ex == 31) && !xn;
        yi = (ey == 31) && !yn;
        xz = (ex == 0);
        yz = (ey == 0);
        if (xn || yn || (xi && yz) || (yi && xz)) return 16'h7E00;
        if (xi || yi) return {s, 15'h7C00};
        if (xz || yz) return {s, 15'h0000};
        p = longint'(1024 + int'(x[9:0])) * longint'(1024 + int'(y[9:0]));
        k = 0;
        for (int i = 0; i < 24; i++) if (p[i]) k = i;
        sh   = k - 10;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        e    = ex + ey - 15 + (k - 20);
`ifdef FP16_MUL_RNE_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
`endif
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return {s, 15'h0000};
        return {s, 5'(e), 10'(q)};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s bpc=%0d ops=%h got=%h want=%h", name, 1 << idx, cur_ops, act, exp);
        end
    endtask

    // One operation on all instances; optional stray start pulse at accept+3
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [15:0] te, input bit restart);
        int          first_v [3];
        int          nv      [3];
        bit          busy_bad[3];
        logic [15:0] rv      [3];
        for (int i = 0; i < 3; i++) begin
            first_v[i] = -1; nv[i] = 0; busy_bad[i] = 1'b0; rv[i] = 16'h0;
        end
        cur_ops = {ta, tb_v};
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (valid_w[i] === 1'b1) begin
                    nv[i]++;
                    if (first_v[i] < 0) begin
                        first_v[i] = n;
                        rv[i] = result_w[i];
                    end
                end
                if (busy_w[i] !== ((n <= iters(i) + 1) ? 1'b1 : 1'b0)) busy_bad[i] = 1'b1;
            end
            if (restart && n == 3) begin
                a = 16'h4400; b = 16'h4400; start = 1'b1;
            end
            if (restart && n == 4) start = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            chk("latency", i, first_v[i], iters(i) + 2);
            chk("valid_pulses", i, nv[i], 1);
            chk("result", i, {16'h0, rv[i]}, {16'h0, te});
            chk("busy_window", i, {31'h0, busy_bad[i]}, 32'h0);
        end
    endtask

    vec_t        tbl [14];
    int          nv_c[3];
    logic [15:0] ra, rb;

    initial begin
        tbl[0]  = '{16'h3C00, 16'h4000, 16'h4000};
        tbl[1]  = '{16'h3E00, 16'h3E00, 16'h4080};
        tbl[2]  = '{16'hBC00, 16'h4200, 16'hC200};
`ifdef FP16_MUL_RNE_EN
        tbl[3]  = '{16'h3E00, 16'h3C01, 16'h3E02};
        tbl[13] = '{16'h3E00, 16'h3D55, 16'h4000};
`else
        tbl[3]  = '{16'h3E00, 16'h3C01, 16'h3E01};
        tbl[13] = '{16'h3E00, 16'h3D55, 16'h3FFF};
`endif
        tbl[4]  = '{16'h7BFF, 16'h4000, 16'h7C00};
        tbl[5]  = '{16'hFC00, 16'h0000, 16'h7E00};
        tbl[6]  = '{16'h7C00, 16'hC000, 16'hFC00};
        tbl[7]  = '{16'h0400, 16'h3800, 16'h0000};
        tbl[8]  = '{16'h0001, 16'h3C00, 16'h0000};
        tbl[9]  = '{16'h7E00, 16'h3C00, 16'h7E00};
        tbl[10] = '{16'h8000, 16'h4000, 16'h8000};
        tbl[11] = '{16'h7BFF, 16'h3C00, 16'h7BFF};
        tbl[12] = '{16'h0400, 16'h3C00, 16'h0400};

        reset = 1'b1; start = 1'b0; clear = 1'b0; a = 16'h0; b = 16'h0;
        cur_ops = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_busy", i, {31'h0, busy_w[i]}, 32'h0);
            chk("reset_valid", i, {31'h0, valid_w[i]}, 32'h0);
            chk("reset_result", i, {16'h0, result_w[i]}, 32'h0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 14; v++) run_op(tbl[v].a, tbl[v].b, tbl[v].r, 1'b0);

        // Clear at accept+5 drops the op and leaves the result register alone
        run_op(16'h3C00, 16'h4000, 16'h4000, 1'b0);
        cur_ops = {16'h3E00, 16'h3E00};
        a = 16'h3E00; b = 16'h3E00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("clear_busy", i, {31'h0, busy_w[i]}, 32'h0);
            chk("clear_valid", i, {31'h0, valid_w[i]}, 32'h0);
            nv_c[i] = 0;
        end
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < 3; i++) if (valid_w[i] === 1'b1) nv_c[i]++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk("clear_no_valid", i, nv_c[i], 0);
            chk("clear_hold", i, {16'h0, result_w[i]}, (i == 2) ? 32'h4080 : 32'h4000);
        end

        // Start directly after a clear, then a stray start mid-operation
        run_op(16'h3C00, 16'h4000, 16'h4000, 1'b0);
        run_op(16'hBC00, 16'h4200, 16'hC200, 1'b1);

        // Reset mid-operation
        cur_ops = {16'h3E00, 16'h3E00};
        a = 16'h3E00; b = 16'h3E00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_busy", i, {31'h0, busy_w[i]}, 32'h0);
            chk("midrst_valid", i, {31'h0, valid_w[i]}, 32'h0);
            chk("midrst_result", i, {16'h0, result_w[i]}, 32'h0);
            nv_c[i] = 0;
        end
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (valid_w[i] === 1'b1) nv_c[i]++;
        end
        for (int i = 0; i < 3; i++) chk("midrst_no_valid", i, nv_c[i], 0);

        // Random normal operands against the reference model
        for (int r = 0; r < 60; r++) begin
            ra = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            rb = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            run_op(ra, rb, ref_mul(ra, rb), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
